// File: rtl/cmd_frame_if.sv
// Command-frame bus bundle: the received byte stream going into the controller
// and the register-file / ALU control outputs coming out of it.
// The slave modport is the controller's view; master is the driver/observer view.
// Width parameters must match the ones given to cmd_frame_ctrl.
interface cmd_frame_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
);
  // byte stream
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  // register file control
  logic              rf_wr_en;
  logic              rf_rd_en;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wr_data;
  // ALU control
  logic              alu_en;
  logic [FUN_W-1:0]  alu_fun;
  logic              clk_gate_en;
  // status
  logic              busy;
  logic              frame_err;

  modport slave (
    input  rx_valid, rx_data,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
    output alu_en, alu_fun, clk_gate_en, busy, frame_err
  );

  modport master (
    output rx_valid, rx_data,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
    input  alu_en, alu_fun, clk_gate_en, busy, frame_err
  );
endinterface

// File: rtl/cmd_frame_ctrl.sv
// cmd_frame_ctrl: decodes a byte-serial command stream into register-file
// writes/reads and ALU execute strobes. Frames:
//   AA addr data      -> register write
//   BB addr           -> register read
//   CC opa opb fun    -> write operands to OPA_ADDR/OPB_ADDR, then execute
//   DD fun            -> execute only
// Any other opcode byte in IDLE pulses frame_err.
// All outputs are registered: a byte accepted on edge N shows its effect
// in the cycle following that edge.
// Optional inter-byte timeout: define CMD_TIMEOUT_EN to build a counter that
// abandons a frame after TIMEOUT idle cycles and pulses frame_err. Without the
// macro there is no counter and the controller waits indefinitely mid-frame.
module cmd_frame_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int FUN_W    = 4,
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  cmd_frame_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    OPA     = 3'd4,
    OPB     = 3'd5,
    FUNC    = 3'd6
  } state_t;

  // Opcode bytes, zero-extended to the byte width
  localparam logic [DATA_W-1:0] OP_WRITE = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OP_READ  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] OP_OPND  = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] OP_FUNC  = DATA_W'(8'hDD);

  localparam logic [ADDR_W-1:0] OPA_A = ADDR_W'(OPA_ADDR);
  localparam logic [ADDR_W-1:0] OPB_A = ADDR_W'(OPB_ADDR);

  state_t            state_q,      state_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic              rf_wr_en_q,   rf_wr_en_d;
  logic              rf_rd_en_q,   rf_rd_en_d;
  logic [ADDR_W-1:0] rf_addr_q,    rf_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic              alu_en_q,     alu_en_d;
  logic [FUN_W-1:0]  alu_fun_q,    alu_fun_d;
  logic              clk_gate_q,   clk_gate_d;
  logic              busy_q,       busy_d;
  logic              frame_err_q,  frame_err_d;

  // High in the cycle the inter-byte timeout expires (never without the macro)
  logic              timeout_hit;

`ifdef CMD_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // The last idle cycle before expiry is when the count would reach TIMEOUT;
  // a byte arriving in that same cycle wins, so rx_valid blocks the hit.
  assign timeout_hit = (state_q != IDLE) && !bus.rx_valid &&
                       (tmo_cnt_q == 16'(TIMEOUT - 1));

  // Count consecutive mid-frame cycles without a byte; any byte or IDLE clears it
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q != IDLE) && !bus.rx_valid && !timeout_hit) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // No timeout hardware: TIMEOUT is accepted but has no effect in this build
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state and next-output decode; every output defaults to its idle value
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = '0;
    rf_wr_data_d = '0;
    alu_en_d     = 1'b0;
    alu_fun_d    = '0;
    frame_err_d  = 1'b0;

    if (timeout_hit) begin
      // Abandon the frame: no strobe, just the error pulse
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == OP_WRITE) begin
            state_d = WR_ADDR;
          end else if (bus.rx_data == OP_READ) begin
            state_d = RD_ADDR;
          end else if (bus.rx_data == OP_OPND) begin
            state_d = OPA;
          end else if (bus.rx_data == OP_FUNC) begin
            state_d = FUNC;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        WR_ADDR: begin
          addr_d  = bus.rx_data[ADDR_W-1:0];
          state_d = WR_DATA;
        end
        WR_DATA: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = bus.rx_data;
          state_d      = IDLE;
        end
        RD_ADDR: begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = bus.rx_data[ADDR_W-1:0];
          state_d    = IDLE;
        end
        OPA: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = OPA_A;
          rf_wr_data_d = bus.rx_data;
          state_d      = OPB;
        end
        OPB: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = OPB_A;
          rf_wr_data_d = bus.rx_data;
          state_d      = FUNC;
        end
        FUNC: begin
          alu_en_d  = 1'b1;
          alu_fun_d = bus.rx_data[FUN_W-1:0];
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Status outputs follow the next state so their registers track state_q
    busy_d     = (state_d != IDLE);
    clk_gate_d = (state_d == OPB) || (state_d == FUNC) || alu_en_d;
  end

  // State and output registers; reset abandons any frame with all outputs low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      clk_gate_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      clk_gate_q   <= clk_gate_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = clk_gate_q;
  assign bus.busy        = busy_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Bench for cmd_frame_ctrl: directed byte frames with a scoreboard of
// expected strobe events (cycle, strobe set, address, data, function).
// Compile with +define+CMD_TIMEOUT_EN to exercise the timeout build.
module tb_cmd_frame_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;

  // strobe vector layout: {rf_wr_en, rf_rd_en, alu_en, frame_err}
  localparam logic [3:0] EV_WR  = 4'b1000;
  localparam logic [3:0] EV_RD  = 4'b0100;
  localparam logic [3:0] EV_ALU = 4'b0010;
  localparam logic [3:0] EV_ERR = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cmd_frame_if #(.DATA_W(DW), .ADDR_W(AW), .FUN_W(FW)) bus ();

  cmd_frame_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .FUN_W(FW),
    .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            cyc;
    logic [3:0]    strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [FW-1:0] fun;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [3:0] mon_strb;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Queue an expected event dly edges after the current drive point
  task automatic expect_ev(input logic [3:0] strb, input int addr, input int wdata,
                           input int fun, input int dly);
    exp_t e;
    e.cyc   = cyc + dly;
    e.strb  = strb;
    e.addr  = AW'(addr);
    e.wdata = DW'(wdata);
    e.fun   = FW'(fun);
    sb_q.push_back(e);
  endtask

  // Drive one byte for one cycle (called just after a rising edge), then
  // check busy / clk_gate_en right after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input logic exp_busy, input logic exp_gate);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    check_eq($sformatf("busy_after_%02h", b), 32'(bus.busy), 32'(exp_busy));
    check_eq($sformatf("gate_after_%02h", b), 32'(bus.clk_gate_en), 32'(exp_gate));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 32'({bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data,
                       bus.alu_en, bus.alu_fun, bus.clk_gate_en, bus.busy,
                       bus.frame_err}), 32'd0);
  endtask

  // Output monitor: every strobe cycle is matched against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      mon_strb = {bus.rf_wr_en, bus.rf_rd_en, bus.alu_en, bus.frame_err};
      if (mon_strb != 4'b0000) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_strobe", 32'(mon_strb), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("txn cyc=%0d strb=%b addr=%0h wdata=%02h fun=%0h",
                   cyc, mon_strb, bus.rf_addr, bus.rf_wr_data, bus.alu_fun);
          check_eq("ev_cycle",   32'(cyc),            32'(mon_e.cyc));
          check_eq("ev_strobes", 32'(mon_strb),       32'(mon_e.strb));
          check_eq("ev_addr",    32'(bus.rf_addr),    32'(mon_e.addr));
          check_eq("ev_wdata",   32'(bus.rf_wr_data), 32'(mon_e.wdata));
          check_eq("ev_fun",     32'(bus.alu_fun),    32'(mon_e.fun));
        end
      end else begin
        check_eq("idle_fields_zero", 32'({bus.rf_addr, bus.rf_wr_data, bus.alu_fun}), 32'd0);
      end
    end
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    // Reset state
    #2;
    check_all_zero("reset_outputs");
    idle(2);
    rst = 1'b1;

    // Write frame, accepted on the first edge after reset release
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    expect_ev(EV_WR, 5, 8'h3C, 0, 1);
    send_byte(8'h3C, 1'b0, 1'b0);

    // Read frame, back to back
    send_byte(8'hBB, 1'b1, 1'b0);
    expect_ev(EV_RD, 4'hA, 0, 0, 1);
    send_byte(8'h0A, 1'b0, 1'b0);

    // Operand + function frame
    send_byte(8'hCC, 1'b1, 1'b0);
    expect_ev(EV_WR, 0, 8'h12, 0, 1);
    send_byte(8'h12, 1'b1, 1'b1);
    expect_ev(EV_WR, 1, 8'h34, 0, 1);
    send_byte(8'h34, 1'b1, 1'b1);
    expect_ev(EV_ALU, 0, 0, 2, 1);
    send_byte(8'h02, 1'b0, 1'b1);
    idle(1);
    check_eq("gate_after_alu", 32'(bus.clk_gate_en), 32'd0);

    // Bad opcode, then an immediate function-only frame
    expect_ev(EV_ERR, 0, 0, 0, 1);
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'hDD, 1'b1, 1'b1);
    expect_ev(EV_ALU, 0, 0, 7, 1);
    send_byte(8'h07, 1'b0, 1'b1);

    // Upper bits of address / function bytes are ignored
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hF5, 1'b1, 1'b0);
    expect_ev(EV_WR, 5, 8'hA7, 0, 1);
    send_byte(8'hA7, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0);
    expect_ev(EV_RD, 4'hA, 0, 0, 1);
    send_byte(8'hFA, 1'b0, 1'b0);
    send_byte(8'hDD, 1'b1, 1'b1);
    expect_ev(EV_ALU, 0, 0, 7, 1);
    send_byte(8'h97, 1'b0, 1'b1);
    idle(2);

    // Reset between operand bytes abandons the frame
    send_byte(8'hCC, 1'b1, 1'b0);
    expect_ev(EV_WR, 0, 8'h12, 0, 1);
    send_byte(8'h12, 1'b1, 1'b1);
    idle(1);
    check_eq("busy_before_reset", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    idle(2);
    rst = 1'b1;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    expect_ev(EV_WR, 1, 8'hFF, 0, 1);
    send_byte(8'hFF, 1'b0, 1'b0);
    idle(2);

`ifdef CMD_TIMEOUT_EN
    // Four idle cycles mid-frame expire the frame (TIMEOUT = 4)
    expect_ev(EV_ERR, 0, 0, 0, 5);
    send_byte(8'hAA, 1'b1, 1'b0);
    idle(3);
    check_eq("busy_before_timeout", 32'(bus.busy), 32'd1);
    idle(1);
    check_eq("busy_after_timeout", 32'(bus.busy), 32'd0);
    idle(2);
    // A byte on the fourth idle cycle wins over the timeout
    send_byte(8'hAA, 1'b1, 1'b0);
    idle(3);
    send_byte(8'h05, 1'b1, 1'b0);
    expect_ev(EV_WR, 5, 8'h3C, 0, 1);
    send_byte(8'h3C, 1'b0, 1'b0);
`else
    // Without the timeout the controller waits indefinitely mid-frame
    send_byte(8'hAA, 1'b1, 1'b0);
    idle(300);
    check_eq("busy_long_wait", 32'(bus.busy), 32'd1);
    send_byte(8'h05, 1'b1, 1'b0);
    expect_ev(EV_WR, 5, 8'h3C, 0, 1);
    send_byte(8'h3C, 1'b0, 1'b0);
`endif

    idle(3);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_ctrl.md
CMD_FRAME_CTRL -- requirements
Module: cmd_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of the received byte and of the register-file write data.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning the register-file address width (ADDR_W <= DATA_W).
REQ-003 SHALL have parameter FUN_W, default 4, meaning the ALU function code width (FUN_W <= DATA_W).
REQ-004 SHALL have parameter OPA_ADDR, default 0, meaning the register-file address that receives operand A.
REQ-005 SHALL have parameter OPB_ADDR, default 1, meaning the register-file address that receives operand B.
REQ-006 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of idle cycles allowed between bytes of one frame (range 1 to 65535).
REQ-007 SHALL have port clk, input, 1 bit: the clock; all logic samples on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port rx_valid, input, 1 bit: a one-cycle strobe marking one received byte.
REQ-010 SHALL have port rx_data, input, DATA_W bits: the received byte, valid while rx_valid is high.
REQ-011 SHALL have port rf_wr_en, output, 1 bit: the register-file write strobe.
REQ-012 SHALL have port rf_rd_en, output, 1 bit: the register-file read strobe.
REQ-013 SHALL have port rf_addr, output, ADDR_W bits: the register-file address.
REQ-014 SHALL have port rf_wr_data, output, DATA_W bits: the register-file write data.
REQ-015 SHALL have port alu_en, output, 1 bit: the ALU execute strobe.
REQ-016 SHALL have port alu_fun, output, FUN_W bits: the ALU function code.
REQ-017 SHALL have port clk_gate_en, output, 1 bit: the ALU clock-gate enable.
REQ-018 SHALL have port busy, output, 1 bit: high while a frame is in progress (state not IDLE).
REQ-019 SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a bad opcode or a timeout.

Function
REQ-020 SHALL implement the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUNC.
REQ-021 SHALL change state only on an accepted byte (rx_valid high) or on a timeout; a state with no accepted byte holds.
REQ-022 In IDLE, SHALL decode rx_data: 0xAA goes to WR_ADDR, 0xBB to RD_ADDR, 0xCC to OPA, 0xDD to FUNC; any other value pulses frame_err and stays in IDLE.
REQ-023 WR_ADDR SHALL latch rx_data[ADDR_W-1:0] into the internal address register and go to WR_DATA.
REQ-024 WR_DATA SHALL issue a write of rx_data to the latched address and go to IDLE.
REQ-025 RD_ADDR SHALL issue a read of rx_data[ADDR_W-1:0] and go to IDLE.
REQ-026 OPA SHALL issue a write of rx_data to OPA_ADDR and go to OPB.
REQ-027 OPB SHALL issue a write of rx_data to OPB_ADDR and go to FUNC.
REQ-028 FUNC SHALL issue alu_en with alu_fun = rx_data[FUN_W-1:0] and go to IDLE.
REQ-029 All outputs SHALL be registered: a byte accepted in cycle N produces its strobe, address, data or function in cycle N+1 only.
REQ-030 Each strobe (rf_wr_en, rf_rd_en, alu_en) SHALL be high for exactly one cycle per issue.
REQ-031 rf_addr, rf_wr_data and alu_fun SHALL be zero whenever their associated strobe is low.
REQ-032 clk_gate_en SHALL be high while in OPB or FUNC and during the alu_en cycle, and low otherwise.
REQ-033 busy SHALL equal (state != IDLE), registered.
REQ-034 Bits of rx_data above ADDR_W or FUN_W SHALL be ignored.
REQ-035 Back-to-back frames SHALL be accepted with no dead cycle: an opcode byte may arrive in the cycle immediately after the last byte of the previous frame.

Reset
REQ-036 On rst low, the block SHALL asynchronously force state to IDLE, clear the timeout counter, and drive every output to 0.
REQ-037 A reset asserted mid-frame SHALL abandon the frame with no strobe issued.
REQ-038 After reset deasserts, the block SHALL accept an opcode byte on the first clock edge.

Configuration
REQ-039 With macro CMD_TIMEOUT_EN defined, the block SHALL count consecutive non-IDLE cycles without rx_valid, clearing the count on every accepted byte.
REQ-040 With CMD_TIMEOUT_EN defined, when the count reaches TIMEOUT the block SHALL return to IDLE and pulse frame_err in the next cycle with no strobe issued.
REQ-041 With CMD_TIMEOUT_EN defined, if rx_valid arrives in the same cycle the count reaches TIMEOUT, the byte SHALL take priority and no timeout SHALL occur.
REQ-042 Without CMD_TIMEOUT_EN, the block SHALL contain no counter, SHALL wait indefinitely in any state, and frame_err SHALL pulse only on a bad opcode.

Verification
REQ-043 Bytes AA, 05, 3C -> exactly one rf_wr_en pulse with rf_addr = 5 and rf_wr_data = 0x3C, one cycle after the 3C byte.
REQ-044 Bytes BB, 0A -> one rf_rd_en pulse with rf_addr = 0xA; no write pulse.
REQ-045 Bytes CC, 12, 34, 02 -> writes 0x12 to address 0 and 0x34 to address 1, then alu_en with alu_fun = 2; clk_gate_en high from entry to OPB through the alu_en cycle.
REQ-046 Byte 0x55 in IDLE -> one frame_err pulse, busy stays 0; an immediate follow-on frame DD, 07 -> alu_en with alu_fun = 7.
REQ-047 With CMD_TIMEOUT_EN and TIMEOUT = 4: AA followed by 4 idle cycles -> frame_err pulse and return to IDLE; the same frame with rx_valid on the 4th idle cycle -> no error.
REQ-048 Reset pulsed between bytes 12 and 34 of a CC frame -> no further strobes; the next frame AA, 01, FF completes normally.
